// File: rtl/bus_pkg.sv
// Shared definitions for the single-bus register core: datapath width and
// the bus source codes produced by the encoder and consumed by the bus mux.
package bus_pkg;

  localparam int DW = 32;

  localparam logic [4:0] SRC_R0     = 5'd0;
  localparam logic [4:0] SRC_R15    = 5'd15;
  localparam logic [4:0] SRC_HI     = 5'd16;
  localparam logic [4:0] SRC_LO     = 5'd17;
  localparam logic [4:0] SRC_ZHI    = 5'd18;
  localparam logic [4:0] SRC_ZLO    = 5'd19;
  localparam logic [4:0] SRC_PC     = 5'd20;
  localparam logic [4:0] SRC_MDR    = 5'd21;
  localparam logic [4:0] SRC_INPORT = 5'd22;
  localparam logic [4:0] SRC_C      = 5'd23;
  localparam logic [4:0] SRC_NONE   = 5'd31;

endpackage

// File: rtl/bus_src_encoder.sv
// 32-to-5 priority encoder: reports the lowest-numbered asserted request,
// or SRC_NONE when nothing is requested. Purely combinational.
module bus_src_encoder
  import bus_pkg::*;
(
  input  logic [31:0] req_i,
  output logic [4:0]  sel_o
);

  // Scan from the top down so the lowest asserted index is the last one written
  always_comb begin
    sel_o = SRC_NONE;
    for (int i = 31; i >= 0; i--) begin
      if (req_i[i]) sel_o = 5'(i);
    end
  end

endmodule

// File: rtl/bus_regfile_core.sv
// Register file and shared bus of the single-bus CPU datapath (no ALU).
// R0-R15, HI, LO, PC, IR, Y load from the bus; Z_HI/Z_LO load from the
// external ALU result; MDR loads from memory or from the bus.
module bus_regfile_core #(
  parameter int DW = bus_pkg::DW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [15:0]   r_in,
  input  logic [15:0]   r_out,
  input  logic          pc_in,
  input  logic          ir_in,
  input  logic          y_in,
  input  logic          hi_in,
  input  logic          lo_in,
  input  logic          z_in,
  input  logic          mdr_in,
  input  logic          read,
  input  logic          pc_out,
  input  logic          mdr_out,
  input  logic          hi_out,
  input  logic          lo_out,
  input  logic          zhigh_out,
  input  logic          zlow_out,
  input  logic          inport_out,
  input  logic          c_out,
  input  logic [DW-1:0] mdata_in,
  input  logic [DW-1:0] inport_data,
  input  logic [DW-1:0] c_sign_ext,
  input  logic [DW-1:0] alu_lo,
  input  logic [DW-1:0] alu_hi,
  output logic [DW-1:0] bus_out,
  output logic [4:0]    bus_sel,
  output logic [DW-1:0] y_q,
  output logic [DW-1:0] ir_q,
  output logic [DW-1:0] pc_q,
  output logic [DW-1:0] mdr_q
);

  import bus_pkg::*;

  logic [DW-1:0] r_q [16];
  logic [DW-1:0] hi_q, lo_q, zhi_q, zlo_q, pc_r_q, ir_r_q, y_r_q, mdr_r_q;
  logic [DW-1:0] mdr_d;
  logic [31:0]   enc_req;

  // Out strobes packed in source-code order; bits 24-31 are never requested
  assign enc_req = {8'h00, c_out, inport_out, mdr_out, pc_out,
                    zlow_out, zhigh_out, lo_out, hi_out, r_out};

  bus_src_encoder u_enc (
    .req_i (enc_req),
    .sel_o (bus_sel)
  );

  // Bus multiplexer: follows the registers with zero latency, unused codes drive 0
  always_comb begin
    bus_out = '0;
    if (bus_sel <= SRC_R15) begin
      bus_out = r_q[bus_sel[3:0]];
    end else begin
      case (bus_sel)
        SRC_HI:     bus_out = hi_q;
        SRC_LO:     bus_out = lo_q;
        SRC_ZHI:    bus_out = zhi_q;
        SRC_ZLO:    bus_out = zlo_q;
        SRC_PC:     bus_out = pc_r_q;
        SRC_MDR:    bus_out = mdr_r_q;
        SRC_INPORT: bus_out = inport_data;
        SRC_C:      bus_out = c_sign_ext;
        default:    bus_out = '0;
      endcase
    end
  end

  assign mdr_d = read ? mdata_in : bus_out;

  // General-purpose registers R0-R15: clear wins over load, otherwise hold
  always_ff @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (clr)          r_q[i] <= '0;
      else if (r_in[i]) r_q[i] <= bus_out;
    end
  end

  // Special registers: bus-loaded HI/LO/PC/IR/Y, ALU-loaded Z pair, MDR from memory or bus
  always_ff @(posedge clk) begin
    if (clr) begin
      hi_q    <= '0;
      lo_q    <= '0;
      zhi_q   <= '0;
      zlo_q   <= '0;
      pc_r_q  <= '0;
      ir_r_q  <= '0;
      y_r_q   <= '0;
      mdr_r_q <= '0;
    end else begin
      if (hi_in)  hi_q    <= bus_out;
      if (lo_in)  lo_q    <= bus_out;
      if (pc_in)  pc_r_q  <= bus_out;
      if (ir_in)  ir_r_q  <= bus_out;
      if (y_in)   y_r_q   <= bus_out;
      if (mdr_in) mdr_r_q <= mdr_d;
      if (z_in) begin
        zhi_q <= alu_hi;
        zlo_q <= alu_lo;
      end
    end
  end

  assign y_q   = y_r_q;
  assign ir_q  = ir_r_q;
  assign pc_q  = pc_r_q;
  assign mdr_q = mdr_r_q;

endmodule

// File: tb/tb_bus_regfile_core.sv
// Directed testbench for bus_regfile_core with hand-computed expected values.
module tb_bus_regfile_core;

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] r_in, r_out;
  logic        pc_in, ir_in, y_in, hi_in, lo_in, z_in, mdr_in, read;
  logic        pc_out, mdr_out, hi_out, lo_out, zhigh_out, zlow_out, inport_out, c_out;
  logic [31:0] mdata_in, inport_data, c_sign_ext, alu_lo, alu_hi;
  logic [31:0] bus_out, y_q, ir_q, pc_q, mdr_q;
  logic [4:0]  bus_sel;

  int n_checks = 0;
  int n_pass   = 0;

  bus_regfile_core #(.DW(32)) dut (
    .clk(clk), .clr(clr), .r_in(r_in), .r_out(r_out),
    .pc_in(pc_in), .ir_in(ir_in), .y_in(y_in), .hi_in(hi_in), .lo_in(lo_in),
    .z_in(z_in), .mdr_in(mdr_in), .read(read),
    .pc_out(pc_out), .mdr_out(mdr_out), .hi_out(hi_out), .lo_out(lo_out),
    .zhigh_out(zhigh_out), .zlow_out(zlow_out), .inport_out(inport_out), .c_out(c_out),
    .mdata_in(mdata_in), .inport_data(inport_data), .c_sign_ext(c_sign_ext),
    .alu_lo(alu_lo), .alu_hi(alu_hi),
    .bus_out(bus_out), .bus_sel(bus_sel),
    .y_q(y_q), .ir_q(ir_q), .pc_q(pc_q), .mdr_q(mdr_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic strobes_off();
    clr = 0; r_in = '0; r_out = '0;
    pc_in = 0; ir_in = 0; y_in = 0; hi_in = 0; lo_in = 0; z_in = 0; mdr_in = 0; read = 0;
    pc_out = 0; mdr_out = 0; hi_out = 0; lo_out = 0;
    zhigh_out = 0; zlow_out = 0; inport_out = 0; c_out = 0;
  endtask

  // Advance one rising edge, then step off it before touching inputs or sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    strobes_off();
    mdata_in = '0; inport_data = '0; c_sign_ext = '0; alu_lo = '0; alu_hi = '0;
    settle();

    // Preload non-zero values so the clear has something to wipe
    inport_data = 32'h1111_1111; inport_out = 1;
    pc_in = 1; y_in = 1; ir_in = 1; r_in = 16'h0020;
    read = 1; mdata_in = 32'h0000_2222; mdr_in = 1;
    tick();
    strobes_off(); settle();
    check("preload_pc", pc_q, 32'h1111_1111);
    check("preload_mdr", mdr_q, 32'h0000_2222);

    // Clear with loads asserted: everything zero, loads discarded
    clr = 1; r_in = 16'hFFFF; y_in = 1; pc_in = 1; ir_in = 1; mdr_in = 1; read = 1;
    inport_out = 1;
    tick();
    strobes_off(); settle();
    check("clr_bus", bus_out, 32'h0);
    check("clr_sel_none", {27'h0, bus_sel}, 32'd31);
    check("clr_y", y_q, 32'h0);
    check("clr_ir", ir_q, 32'h0);
    check("clr_pc", pc_q, 32'h0);
    check("clr_mdr", mdr_q, 32'h0);
    r_out[5] = 1; settle();
    check("clr_r5", bus_out, 32'h0);
    check("clr_r5_sel", {27'h0, bus_sel}, 32'd5);
    strobes_off();

    // Memory read into MDR, then MDR -> R2
    read = 1; mdata_in = 32'h0000_0022; mdr_in = 1;
    tick();
    strobes_off();
    mdr_out = 1; r_in[2] = 1; settle();
    check("mdr_bus", bus_out, 32'h0000_0022);
    check("mdr_sel", {27'h0, bus_sel}, 32'd21);
    tick();
    strobes_off();
    r_out[2] = 1; settle();
    check("r2_bus", bus_out, 32'h0000_0022);
    strobes_off();

    // Overwrite MDR from memory, then MDR loads from the bus (R2)
    read = 1; mdata_in = 32'h0000_0055; mdr_in = 1;
    tick();
    strobes_off(); settle();
    check("mdr_mem55", mdr_q, 32'h0000_0055);
    r_out[2] = 1; mdr_in = 1; read = 0;
    tick();
    strobes_off(); settle();
    check("mdr_from_bus", mdr_q, 32'h0000_0022);

    // Load R3 and PC, then exercise priority
    inport_data = 32'h0000_0033; inport_out = 1; r_in[3] = 1;
    tick();
    strobes_off();
    c_sign_ext = 32'hFFFF_FF00; c_out = 1; pc_in = 1;
    tick();
    strobes_off(); settle();
    check("pc_from_c", pc_q, 32'hFFFF_FF00);
    r_out[3] = 1; pc_out = 1; settle();
    check("prio_sel", {27'h0, bus_sel}, 32'd3);
    check("prio_bus", bus_out, 32'h0000_0033);
    strobes_off();
    inport_data = 32'hDEAD_BEEF; inport_out = 1; settle();
    check("inport_sel", {27'h0, bus_sel}, 32'd22);
    check("inport_bus", bus_out, 32'hDEAD_BEEF);
    c_out = 1; settle();
    check("inport_over_c", {27'h0, bus_sel}, 32'd22);
    inport_out = 0; settle();
    check("c_sel", {27'h0, bus_sel}, 32'd23);
    check("c_bus", bus_out, 32'hFFFF_FF00);
    strobes_off();
    pc_out = 1; settle();
    check("pc_bus", bus_out, 32'hFFFF_FF00);
    strobes_off();

    // Z pair from the ALU; Y loads Z_LO from the bus
    alu_hi = 32'h0000_0001; alu_lo = 32'hFFFF_FFFE; z_in = 1;
    tick();
    strobes_off();
    alu_hi = 32'h0; alu_lo = 32'h0;
    zhigh_out = 1; settle();
    check("zhi_bus", bus_out, 32'h0000_0001);
    check("zhi_sel", {27'h0, bus_sel}, 32'd18);
    strobes_off();
    zlow_out = 1; y_in = 1; settle();
    check("zlo_bus", bus_out, 32'hFFFF_FFFE);
    tick();
    strobes_off(); settle();
    check("y_from_zlo", y_q, 32'hFFFF_FFFE);

    // Same-cycle drive and load holds the old value
    r_out[3] = 1; r_in[3] = 1;
    tick();
    strobes_off();
    r_out[3] = 1; settle();
    check("self_load_hold", bus_out, 32'h0000_0033);
    strobes_off();

    // Multiple loads capture one bus value; HI/LO loads
    inport_data = 32'h0000_0077; inport_out = 1; r_in = 16'h0030; ir_in = 1; hi_in = 1;
    tick();
    strobes_off();
    c_sign_ext = 32'h0000_5555; c_out = 1; lo_in = 1;
    tick();
    strobes_off(); settle();
    check("multi_ir", ir_q, 32'h0000_0077);
    r_out[4] = 1; settle();
    check("multi_r4", bus_out, 32'h0000_0077);
    strobes_off(); r_out[5] = 1; settle();
    check("multi_r5", bus_out, 32'h0000_0077);
    strobes_off(); hi_out = 1; lo_out = 1; settle();
    check("hi_over_lo_sel", {27'h0, bus_sel}, 32'd16);
    check("hi_bus", bus_out, 32'h0000_0077);
    strobes_off(); lo_out = 1; settle();
    check("lo_bus", bus_out, 32'h0000_5555);
    strobes_off(); r_out = 16'h8001; settle();
    check("r0_over_r15_sel", {27'h0, bus_sel}, 32'd0);
    check("r0_bus", bus_out, 32'h0);
    strobes_off();

    // Clear beats simultaneous Y and MDR loads
    inport_data = 32'h0000_0099; inport_out = 1; clr = 1; y_in = 1; mdr_in = 1;
    tick();
    strobes_off(); settle();
    check("clr_y_load", y_q, 32'h0);
    check("clr_mdr_load", mdr_q, 32'h0);

    // Reload, then hold across five idle cycles
    inport_data = 32'h0000_0abc; inport_out = 1; y_in = 1; pc_in = 1; ir_in = 1; r_in[7] = 1;
    read = 1; mdata_in = 32'h0000_0def; mdr_in = 1;
    tick();
    strobes_off();
    inport_data = 32'h0; mdata_in = 32'h0;
    for (int k = 0; k < 5; k++) tick();
    check("hold_y", y_q, 32'h0000_0abc);
    check("hold_pc", pc_q, 32'h0000_0abc);
    check("hold_ir", ir_q, 32'h0000_0abc);
    check("hold_mdr", mdr_q, 32'h0000_0def);
    r_out[7] = 1; settle();
    check("hold_r7", bus_out, 32'h0000_0abc);
    strobes_off();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_regfile_core.md
Name: bus_regfile_core

Overview:
- Register and bus core of the single-bus CPU datapath; it contains no ALU.
- Holds the 32-bit registers R0–R15, PC, IR, Y, HI, LO, Z_HI, Z_LO and the memory data register MDR.
- A 32-to-5 priority encoder turns the one-hot "out" strobes into a select code, and a 24-source multiplexer drives the shared 32-bit bus.
- Registers load from the bus, Z_HI/Z_LO load from the external ALU result, and MDR loads from memory or from the bus.

Parameters:
- DW, 32, datapath width; all registers and the bus use this width.

Ports:
- clk in 1: rising-edge clock.
- clr in 1: synchronous active-high clear of every register.
- r_in in 16: load strobes; bit i loads Ri.
- r_out in 16: bus-drive strobes; bit i selects Ri.
- pc_in, ir_in, y_in, hi_in, lo_in in 1 each: load strobes.
- z_in in 1: loads Z_HI and Z_LO together.
- mdr_in in 1: MDR load enable.
- read in 1: MDR source select; 1 = mdata_in, 0 = bus.
- pc_out, mdr_out, hi_out, lo_out, zhigh_out, zlow_out, inport_out, c_out in 1 each: bus-drive strobes.
- mdata_in in DW: data from memory.
- inport_data in DW: input port value.
- c_sign_ext in DW: sign-extended immediate.
- alu_lo, alu_hi in DW: ALU result halves.
- bus_out out DW: current bus value.
- bus_sel out 5: encoder code.
- y_q, ir_q, pc_q, mdr_q out DW: register contents, going to the ALU, control and memory.

Behaviour:
- Generic register element:
  - On posedge clk: if clr, q <= 0; else if its load strobe is 1, q <= d; else hold.
  - clr has priority over the load strobe.
  - Every output resets to 0.
- MDR:
  - On posedge clk: if clr, 0; else if mdr_in, q <= (read ? mdata_in : bus_out); else hold.
  - mdr_q = q.
- Z_HI <= alu_hi and Z_LO <= alu_lo when z_in is 1. All other registers load from bus_out.
- Encoder input vector, fixed bit order:
  - bits 0–15 = r_out[15:0]
  - 16 = hi_out, 17 = lo_out, 18 = zhigh_out, 19 = zlow_out
  - 20 = pc_out, 21 = mdr_out, 22 = inport_out, 23 = c_out
  - bits 24–31 = 0
- Encoder rule:
  - bus_sel is the index of the lowest-numbered asserted bit.
  - If no bit is asserted, bus_sel = 31 (NONE).
  - The encoder is purely combinational.
- Multiplexer:
  - Code 0–15 drives Ri; 16 HI; 17 LO; 18 Z_HI; 19 Z_LO; 20 PC; 21 MDR; 22 inport_data; 23 c_sign_ext.
  - Codes 24–31 drive all zeros.
  - The multiplexer is combinational, so bus_out follows the registers with zero latency.
- Same-cycle read/write:
  - A register that drives the bus and loads in the same cycle captures its own old value, i.e. it holds.
  - A load takes effect at the edge and appears on the bus the following cycle.
- Multiple load strobes in one cycle: all targeted registers capture the same bus value.
- Multiple out strobes in one cycle: the priority rule resolves it, and no X reaches the bus.
- clr while load strobes are asserted: all registers become 0 and the loads are discarded.
- y_q, ir_q and pc_q are direct register outputs.

Decomposition:
- Shared package bus_pkg:
  - DW = 32.
  - Source index constants: SRC_R0 = 0 … SRC_R15 = 15, SRC_HI = 16, SRC_LO = 17, SRC_ZHI = 18, SRC_ZLO = 19, SRC_PC = 20, SRC_MDR = 21, SRC_INPORT = 22, SRC_C = 23, SRC_NONE = 31.
- One natural sub-module: bus_src_encoder, the 32-to-5 priority encoder, so it can be unit-tested on its own.
- Register elements and the multiplexer stay inline.

Test Plan:
1. Assert clr for one edge while r_in = 16'hFFFF → all registers 0; with no out strobes, bus_out = 0 and bus_sel = 31.
2. read = 1, mdata_in = 32'h0000_0022, mdr_in = 1 for one edge, then mdr_out = 1 and r_in[2] = 1 for one edge → bus_out = 0x22 and R2 = 0x22. Next cycle, r_out[2] = 1 gives bus_out = 0x22.
3. R2 = 0x22 and r_out[2] = 1, with mdr_in = 1 and read = 0 → MDR captures 0x22 from the bus; mdr_q = 0x22 after the edge.
4. Priority: r_out[3] = 1 and pc_out = 1 together → bus_sel = 3 and bus_out = R3. inport_out alone with inport_data = 0xDEADBEEF → bus_sel = 22 and bus_out = 0xDEADBEEF.
5. z_in = 1 with alu_hi = 0x1, alu_lo = 0xFFFF_FFFE → zhigh_out gives 0x1 and zlow_out gives 0xFFFF_FFFE on bus_out; y_in loads the bus value and y_q matches.
6. clr asserted together with y_in and mdr_in → y_q = 0 and mdr_q = 0 after the edge; with no strobes, every register holds its value across 5 idle cycles.
